// File: rtl/ram_io_if.sv
// CPU-side request/response bus of ram_io.
// master = CPU (drives requests), slave = ram_io (drives results/status).
interface ram_io_if #(
  parameter int ADDRESS_BITWIDTH = 32
);
  logic                        enable;
  logic [ADDRESS_BITWIDTH-1:0] address;
  logic [2:0]                  read_type;
  logic [1:0]                  write_type;
  logic [31:0]                 data_in;
  logic [31:0]                 data_out;
  logic                        data_out_ready;
  logic                        busy;
  logic                        fault;

  modport master (
    output enable, address, read_type, write_type, data_in,
    input  data_out, data_out_ready, busy, fault
  );

  modport slave (
    input  enable, address, read_type, write_type, data_in,
    output data_out, data_out_ready, busy, fault
  );
endinterface

// File: rtl/ram_io.sv
// CPU front end for the cache: turns byte/half/word loads and stores into
// aligned 32-bit cache accesses with lane masks, extends load data, waits out
// misses, and owns one byte-wide memory-mapped LED register.
module ram_io #(
  parameter int                          ADDRESS_BITWIDTH = 32,
  parameter int                          LED_BITWIDTH     = 4,
  parameter logic [ADDRESS_BITWIDTH-1:0] LED_ADDRESS      = {ADDRESS_BITWIDTH{1'b1}}
) (
  input  logic                    clk,
  input  logic                    rst,
  ram_io_if.slave                 cpu,
  output logic [LED_BITWIDTH-1:0] led,
  output logic [31:0]             cache_address,
  output logic [31:0]             cache_data_in,
  output logic [3:0]              cache_write_enable,
  input  logic [31:0]             cache_data_out,
  input  logic                    cache_data_out_ready
);

  typedef enum logic {IDLE, WAIT_CACHE} state_t;

  // access size shares the low two bits of read_type and write_type
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  state_t      state_q, state_d;
  logic        settle_q;     // first WAIT_CACHE cycle: cache has not seen our address yet
  logic [1:0]  lane_q;
  logic [2:0]  rtype_q;
  logic        is_load_q;
  logic [31:0] data_out_q;
  logic        data_out_ready_q;
  logic        fault_q;

  logic        accept, is_load, is_store, led_hit, illegal, done;
  logic [1:0]  size;
  logic [31:0] shifted, load_val;

  // request decode and legality
  always_comb begin
    accept   = cpu.enable && (state_q == IDLE);
    is_load  = cpu.read_type != 3'b000;
    is_store = cpu.write_type != 2'b00;
    size     = is_load ? cpu.read_type[1:0] : cpu.write_type;
    led_hit  = cpu.address == LED_ADDRESS;
    illegal  = (is_load == is_store)
            || (cpu.read_type == 3'b100) || (cpu.read_type == 3'b111)
            || ((size == SZ_HALF) && cpu.address[0])
            || ((size == SZ_WORD) && (cpu.address[1:0] != 2'b00))
            || (led_hit && (size != SZ_BYTE));
    done     = (state_q == WAIT_CACHE) && !settle_q && cache_data_out_ready;
  end

  // load lane extraction and sign/zero extension
  always_comb begin
    shifted = cache_data_out >> {lane_q, 3'b000};
    case (rtype_q[1:0])
      SZ_BYTE: load_val = rtype_q[2] ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_val = rtype_q[2] ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state: only legal non-LED requests go to the cache
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (accept && !illegal && !led_hit) state_d = WAIT_CACHE;
      WAIT_CACHE: if (done) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // datapath: request capture, cache drive, completion and LED register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q           <= 1'b0;
      lane_q             <= 2'b00;
      rtype_q            <= 3'b000;
      is_load_q          <= 1'b0;
      data_out_q         <= 32'h0;
      data_out_ready_q   <= 1'b0;
      fault_q            <= 1'b0;
      led                <= '0;
      cache_address      <= 32'h0;
      cache_data_in      <= 32'h0;
      cache_write_enable <= 4'b0000;
    end else begin
      data_out_ready_q <= 1'b0;
      settle_q         <= 1'b0;
      if (accept) begin
        if (illegal) begin
          fault_q          <= 1'b1;
          data_out_q       <= 32'h0;
          data_out_ready_q <= 1'b1;
        end else if (led_hit) begin
          if (is_store) led        <= cpu.data_in[LED_BITWIDTH-1:0];
          else          data_out_q <= 32'(led);
          data_out_ready_q <= 1'b1;
        end else begin
          cache_address <= 32'({cpu.address[ADDRESS_BITWIDTH-1:2], 2'b00});
          lane_q        <= cpu.address[1:0];
          rtype_q       <= cpu.read_type;
          is_load_q     <= is_load;
          settle_q      <= 1'b1;
          if (is_store) begin
            case (size)
              SZ_BYTE: cache_write_enable <= 4'b0001 << cpu.address[1:0];
              SZ_HALF: cache_write_enable <= 4'b0011 << cpu.address[1:0];
              default: cache_write_enable <= 4'b1111;
            endcase
            cache_data_in <= cpu.data_in << {cpu.address[1:0], 3'b000};
          end
        end
      end
      if (done) begin
        if (is_load_q) data_out_q <= load_val;
        data_out_ready_q   <= 1'b1;
        cache_write_enable <= 4'b0000;
      end
    end
  end

  assign cpu.data_out       = data_out_q;
  assign cpu.data_out_ready = data_out_ready_q;
  assign cpu.busy           = (state_q == WAIT_CACHE);
  assign cpu.fault          = fault_q;

endmodule

// File: doc/ram_io.md
Name: ram_io

Overview:
- CPU-facing front end that sits directly upstream of the Cache and drives its address/data_in/write_enable port.
- Converts byte, half-word and word loads and stores into aligned 32-bit cache accesses with byte-lane masks, and applies sign or zero extension on loads.
- Waits out cache misses, which includes the burst RAM fill.
- Decodes one memory-mapped LED register at the top byte address.

Parameters:
- ADDRESS_BITWIDTH, 32: width of the CPU byte address.
- LED_BITWIDTH, 4: width of the LED register.
- LED_ADDRESS, {ADDRESS_BITWIDTH{1'b1}}: byte address of the LED register. It is byte-access only and does not go to the cache.

Ports:
- clk  in  1  system clock. One clock domain: everything is synchronous to clk.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  request valid; accepted on a rising edge when enable && !busy.
- address  in  ADDRESS_BITWIDTH  CPU byte address.
- read_type  in  3  000 none, 001 byte signed, 010 half signed, 011 word, 101 byte unsigned, 110 half unsigned.
- write_type  in  2  00 none, 01 byte, 10 half, 11 word.
- data_in  in  32  store data, right-aligned.
- data_out  out  32  load result, right-aligned and extended.
- data_out_ready  out  1  one-cycle pulse when a request completes (load or store).
- busy  out  1  request in flight; new requests are ignored.
- fault  out  1  sticky misalignment/illegal-request flag; cleared only by rst.
- led  out  LED_BITWIDTH  LED register.
- cache_address  out  32  word-aligned byte address to the cache.
- cache_data_in  out  32  lane-shifted store data.
- cache_write_enable  out  4  byte-lane write mask.
- cache_data_out  in  32  cache read word.
- cache_data_out_ready  in  1  cache word valid; the line is resident.

Behaviour:
- Reset values: all outputs 0, state IDLE, led 0, fault 0. Assertion of rst mid-request aborts the request immediately. No data_out_ready is produced for the aborted request. Any cache write still in flight is the cache's concern.
- States: IDLE, WAIT_CACHE.
- IDLE behaviour:
  - cache_write_enable is 0 and busy is 0.
  - On an accepted request, decode as below.
- Illegal requests (checked first):
  - read_type and write_type both nonzero, or both zero.
  - read_type 100 or 111.
  - Half access with address[0] != 0.
  - Word access with address[1:0] != 0.
  - Response: set fault, pulse data_out_ready the next cycle with data_out = 0, stay IDLE, no cache access.
- LED_ADDRESS hit:
  - Byte write: led <= data_in[LED_BITWIDTH-1:0].
  - Byte read: data_out = zero-extended led.
  - data_out_ready pulses the next cycle; no cache access.
  - Half or word access to LED_ADDRESS is illegal (fault).
- Cache access, at the accepting edge:
  - Register cache_address = {address[31:2], 2'b00}.
  - Register lane = address[1:0] and the request type.
  - For writes, register cache_write_enable:
    - byte: 0001 << lane
    - half: 0011 << lane
    - word: 1111
  - For writes, register cache_data_in = data_in << (8*lane).
  - Go to WAIT_CACHE; busy = 1.
- WAIT_CACHE behaviour:
  - Hold all cache_* outputs stable.
  - On the first edge with cache_data_out_ready = 1, for a load: data_out <= extract(cache_data_out >> 8*lane), extended per read_type.
  - On that same edge, for any request: data_out_ready <= 1 for one cycle, cache_write_enable <= 0, return to IDLE, busy <= 0 the same edge.
  - The cycle in which cache_data_out_ready is sampled may be the first WAIT_CACHE cycle. Its data is used only if the cache presented the registered address during the previous cycle. Therefore a hit completes exactly 2 edges after the accepting edge.
- Latency:
  - Hit: data_out_ready is high in the cycle after edge A+2, where A is the accepting edge.
  - Miss: data_out_ready follows the first ready after the fill, with no upper bound.
- Back-to-back requests: a request may be accepted on the edge after data_out_ready's rising edge. enable held high is re-sampled each time the block is idle.
- data_out holds its value between completions.

Test Plan:
- Word load with the cache stub returning ready one cycle after the address is presented: address 16 → cache_address 16, cache_write_enable 0000; 2 edges later data_out = 0xD5B8A9C4 with data_out_ready pulsed for exactly 1 cycle.
- Signed/unsigned byte loads, with the cache word at address 8 = 0xAB4C3E6F:
  - byte signed at 11 → 0xFFFFFFAB
  - byte unsigned at 11 → 0x000000AB
  - half signed at 10 → 0xFFFFAB4C
  - half unsigned at 8 → 0x00003E6F
- Stores:
  - byte store at 9 with data_in 0x12 → cache_write_enable 0010, cache_data_in 0x00001200.
  - half store at 10 with data_in 0x8765 → 1100 and 0x87650000.
  - For each, hold until ready, then cache_write_enable returns to 0.
- Miss, with ready withheld for 20 cycles: busy stays 1, the cache_* outputs are stable, and a second enable is ignored; completion occurs one edge after ready.
- Misalignment and LED register:
  - word load at 6 → fault = 1, data_out 0, no change to cache_address or cache_write_enable.
  - byte write 0x5 to LED_ADDRESS → led = 0x5; the read-back returns 0x00000005 with no cache activity.
- rst asserted while in WAIT_CACHE → all outputs immediately 0, no data_out_ready pulse, and the next request behaves normally.
